mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Moore-style multi-cycle control sequencer for the MIPS datapath.
- Replaces single-cycle fetch/decode control. It sequences the shared ALU, PC register, instruction register and single-port memory across IF/ID/EX/MEM/WB states.
- Handles the memory ready handshake with a timeout, and traps illegal opcodes.
- Exposes state and halt for debug.

Parameters:
- WAIT_MAX, 15: maximum cycles a memory state waits for MemRdy before trapping to ILL (range 1..255).

Ports:
- Clk  input  1  clock, rising edge.
- Clrn  input  1  asynchronous active-low reset.
- Op  input  6  Inst[31:26] from IR.
- Funct  input  6  Inst[5:0] from IR.
- Z  input  1  ALU zero flag.
- MemRdy  input  1  memory ready; completes the current memory access.
- PCWr  output  1  PC write enable.
- IRWr  output  1  IR write enable.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRd  output  1  memory read request.
- MemWr  output  1  memory write request.
- RegWr  output  1  register file write enable.
- RegDst  output  1  destination register: 1=rd, 0=rt.
- MemToReg  output  1  write-back source: 1=MDR, 0=ALUOut.
- ALUSrcA  output  1  ALU A source: 0=PC, 1=reg A.
- ALUSrcB  output  2  ALU B source: 00=reg B, 01=4, 10=ext imm, 11=sext imm<<2.
- ExtOp  output  1  immediate extension: 1=sign, 0=zero.
- ALUOp  output  2  00=ADD, 01=SUB, 10=use Funct, 11=OR.
- PCSrc  output  2  PC source: 00=ALU result, 01=ALUOut, 10={PC[31:28],Inst[25:0],00}.
- State  output  4  current state encoding.
- Halt  output  1  1 while in ILL.

Behaviour:
- State encoding (fixed): IF=0, ID=1, EXR=2, EXI=3, ADDR=4, MRD=5, MWR=6, WBR=7, WBI=8, WBL=9, BR=10, JMP=11, ILL=15.
- Reset: while Clrn=0, state=IF and wait counter=0. All outputs are forced to 0, including State=0 and Halt=0, and memory requests are held off. The first active cycle after release is IF.
- Outputs are combinational from state, plus MemRdy/Z/Op where noted. Every output not listed for a state is 0. ALUSrcA=0, ALUSrcB=00, ALUOp=ADD and ExtOp=1 are the defaults.
- IF:
  - MemRd=1, IorD=0, ALUSrcB=01.
  - If MemRdy=1: IRWr=1, PCWr=1, PCSrc=00, next state=ID.
  - Otherwise stay in IF.
- ID: ALUSrcB=11 (precomputes the branch target). Decode of Op/Funct selects the next state:
  - R-type (000000) with Funct in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} goes to EXR. Any other Funct goes to ILL.
  - addi (001000) and ori (001101) go to EXI.
  - lw (100011) and sw (101011) go to ADDR.
  - beq (000100) and bne (000101) go to BR.
  - j (000010) goes to JMP.
  - Any other Op goes to ILL.
- EXR: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state=WBR.
- EXI: ALUSrcA=1, ALUSrcB=10. ALUOp=ADD with ExtOp=1 for addi; ALUOp=OR with ExtOp=0 for ori. Next state=WBI.
- ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1. Next state=MRD for lw, MWR for sw.
- MRD: MemRd=1, IorD=1. Next state=WBL on MemRdy, otherwise stay.
- MWR: MemWr=1, IorD=1. Next state=IF on MemRdy, otherwise stay.
- WBR: RegWr=1, RegDst=1. WBI: RegWr=1. WBL: RegWr=1, MemToReg=1. All three go to IF.
- BR: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSrc=01. PCWr = Z XOR nBranch, where nBranch=(Op==000101). Next state=IF.
- JMP: PCSrc=10, PCWr=1. Next state=IF.
- ILL: Halt=1, all enables 0. ILL is absorbing and is left only via reset.
- Wait counter (8-bit):
  - Cleared on entry to IF, MRD or MWR, and whenever MemRdy=1.
  - Increments each cycle spent in a memory state with MemRdy=0.
  - If the counter reaches WAIT_MAX while MemRdy=0, the next state is ILL. MemRdy arriving in that same cycle takes priority and completes normally.
- Instruction latency:
  - With a zero-wait memory: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction: immediate abort, no further writes, restart at IF.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- When defined:
  - Adds output InstRet (32-bit), cleared by reset.
  - InstRet increments by 1 (wrapping modulo 2^32) on each completion cycle: WBR, WBI, WBL, MWR with MemRdy, BR, and JMP.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then Op=000000, Funct=100000, MemRdy=1 throughout → State 0,1,2,7,0. IRWr and PCWr pulse in cycle 1 only; RegWr=1 and RegDst=1 in cycle 4.
- lw (Op=100011) with MemRdy low for 3 cycles in MRD → State 0,1,4,5,5,5,5,9,0. MemRd and IorD held high through all MRD cycles; MemToReg=1 and RegWr=1 in WBL.
- beq with Z=1 → PCWr=1, PCSrc=01 in BR. bne with Z=1 → PCWr=0. bne with Z=0 → PCWr=1.
- j (Op=000010) → PCSrc=10, PCWr=1 in state 11; 3 cycles total.
- Op=111111, or Op=000000 with Funct=000000 → State=15, Halt=1 held for 20 cycles with all enables 0. Pulse Clrn low → State=0, Halt=0.
- MemRdy held at 0 in IF with WAIT_MAX=15 → ILL entered after 15 wait cycles. Second run with MemRdy=1 on the 15th cycle → normal move to ID.
- With MC_CTRL_PERF_EN defined: sequence add, lw, sw, beq, j → InstRet=5.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer (IF/ID/EX/MEM/WB); optional retire counter under MC_CTRL_PERF_EN.
// Latency: R/I-type 4, lw 5, sw 4, branch/jump 3 cycles, plus 1 per memory wait cycle.
// Backpressure: memory states stall on MemRdy=0; after WAIT_MAX stalled cycles the sequencer traps to ILL.
module mc_ctrl_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       Clk,
    input  logic       Clrn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Z,
    input  logic       MemRdy,
    output logic       PCWr,
    output logic       IRWr,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       RegWr,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] State,
    output logic       Halt
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] InstRet
`endif
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EXR  = 4'd2,
        S_EXI  = 4'd3,
        S_ADDR = 4'd4,
        S_MRD  = 4'd5,
        S_MWR  = 4'd6,
        S_WBR  = 4'd7,
        S_WBI  = 4'd8,
        S_WBL  = 4'd9,
        S_BR   = 4'd10,
        S_JMP  = 4'd11,
        S_ILL  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic [7:0] w_wait_nxt;
    logic       w_mem_state;

    logic       w_pcwr, w_irwr, w_iord, w_memrd, w_memwr;
    logic       w_regwr, w_regdst, w_memtoreg, w_alusrca, w_extop, w_halt;
    logic [1:0] w_alusrcb, w_aluop, w_pcsrc;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_state <= S_IF;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_state = 1'b0;
        w_pcwr      = 1'b0;
        w_irwr      = 1'b0;
        w_iord      = 1'b0;
        w_memrd     = 1'b0;
        w_memwr     = 1'b0;
        w_regwr     = 1'b0;
        w_regdst    = 1'b0;
        w_memtoreg  = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = 2'b00;
        w_extop     = 1'b1;
        w_aluop     = ALU_ADD;
        w_pcsrc     = 2'b00;
        w_halt      = 1'b0;

        case (r_state)
            S_IF: begin
                w_mem_state = 1'b1;
                w_memrd     = 1'b1;
                w_alusrcb   = 2'b01;
                if (MemRdy) begin
                    w_irwr = 1'b1;
                    w_pcwr = 1'b1;
                    w_next = S_ID;
                end
            end
            S_ID: begin
                // Branch target is computed here so BR can take it from ALUOut.
                w_alusrcb = 2'b11;
                case (Op)
                    OP_RTYPE: begin
                        case (Funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_next = S_EXR;
                            default:                               w_next = S_ILL;
                        endcase
                    end
                    OP_ADDI, OP_ORI: w_next = S_EXI;
                    OP_LW, OP_SW:    w_next = S_ADDR;
                    OP_BEQ, OP_BNE:  w_next = S_BR;
                    OP_J:            w_next = S_JMP;
                    default:         w_next = S_ILL;
                endcase
            end
            S_EXR: begin
                w_alusrca = 1'b1;
                w_aluop   = ALU_FN;
                w_next    = S_WBR;
            end
            S_EXI: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                if (Op == OP_ORI) begin
                    w_aluop = ALU_OR;
                    w_extop = 1'b0;
                end
                w_next = S_WBI;
            end
            S_ADDR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                if (Op == OP_SW)
                    w_next = S_MWR;
                else if (Op == OP_LW)
                    w_next = S_MRD;
                else
                    w_next = S_ILL;
            end
            S_MRD: begin
                w_mem_state = 1'b1;
                w_memrd     = 1'b1;
                w_iord      = 1'b1;
                if (MemRdy)
                    w_next = S_WBL;
            end
            S_MWR: begin
                w_mem_state = 1'b1;
                w_memwr     = 1'b1;
                w_iord      = 1'b1;
                if (MemRdy)
                    w_next = S_IF;
            end
            S_WBR: begin
                w_regwr  = 1'b1;
                w_regdst = 1'b1;
                w_next   = S_IF;
            end
            S_WBI: begin
                w_regwr = 1'b1;
                w_next  = S_IF;
            end
            S_WBL: begin
                w_regwr    = 1'b1;
                w_memtoreg = 1'b1;
                w_next     = S_IF;
            end
            S_BR: begin
                w_alusrca = 1'b1;
                w_aluop   = ALU_SUB;
                w_pcsrc   = 2'b01;
                w_pcwr    = Z ^ (Op == OP_BNE);
                w_next    = S_IF;
            end
            S_JMP: begin
                w_pcsrc = 2'b10;
                w_pcwr  = 1'b1;
                w_next  = S_IF;
            end
            S_ILL: begin
                w_halt = 1'b1;
                w_next = S_ILL;
            end
            default: w_next = S_ILL;
        endcase

        // A ready in the last allowed cycle still completes; only a missing one traps.
        if (w_mem_state && !MemRdy && (r_wait == LP_WAIT_LAST))
            w_next = S_ILL;

        // Counting only while parked in the same memory state; entry or ready restarts at zero.
        if (w_mem_state && !MemRdy && (w_next == r_state))
            w_wait_nxt = r_wait + 8'd1;
        else
            w_wait_nxt = '0;
    end

    // Reset overrides the state decode so no request or enable leaks out while Clrn is low.
    assign PCWr     = Clrn & w_pcwr;
    assign IRWr     = Clrn & w_irwr;
    assign IorD     = Clrn & w_iord;
    assign MemRd    = Clrn & w_memrd;
    assign MemWr    = Clrn & w_memwr;
    assign RegWr    = Clrn & w_regwr;
    assign RegDst   = Clrn & w_regdst;
    assign MemToReg = Clrn & w_memtoreg;
    assign ALUSrcA  = Clrn & w_alusrca;
    assign ALUSrcB  = Clrn ? w_alusrcb : 2'b00;
    assign ExtOp    = Clrn & w_extop;
    assign ALUOp    = Clrn ? w_aluop : 2'b00;
    assign PCSrc    = Clrn ? w_pcsrc : 2'b00;
    assign State    = Clrn ? r_state : 4'd0;
    assign Halt     = Clrn & w_halt;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_instret;
    logic        w_retire;

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_WBR, S_WBI, S_WBL, S_BR, S_JMP: w_retire = 1'b1;
            S_MWR:                            w_retire = MemRdy;
            default:                          w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn)
            r_instret <= '0;
        else if (w_retire)
            r_instret <= r_instret + 32'd1;
    end

    assign InstRet = r_instret;
`endif

endmodule
